branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Fetch-side branch predictor and redirect controller for the 5-stage RISC-V pipeline. Predicts taken/target for the PC in IF from a direct-mapped branch history/target table. Checks each control-transfer resolution from EX (branch unit `PC_sel`/`branch_PC`) against the prediction carried down the pipe. Drives the PC redirect and the younger-stage flush on mispredict.

## Interface
Parameters:
- PC_W, 9, program counter width
- IDX_W, 4, table index width (2^IDX_W entries); index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_pc  in  PC_W  PC being fetched
- pred_taken  out  1  prediction for if_pc
- pred_target  out  PC_W  predicted target for if_pc
- ex_valid  in  1  EX holds a valid instruction
- ex_hold  in  1  EX stage frozen this cycle
- ex_pc  in  PC_W  PC of EX instruction
- ex_ctrl_transfer  in  2  00 none, 01 branch, 10 JAL, 11 JALR
- ex_taken  in  1  resolved PC_sel
- ex_target  in  32  resolved branch_PC
- ex_pred_taken  in  1  prediction carried with the EX instruction
- ex_pred_target  in  PC_W  predicted target carried with the EX instruction
- redirect  out  1  PC mux must load redirect_pc; priority over all other PC sources
- redirect_pc  out  32  correct next PC
- flush  out  1  zero IF/ID and ID/EX this edge
- mispredict_cnt  out  16  saturating mispredict count

## Operation
- Entry: valid, tag, target[PC_W], ctr[1:0], jal.
- Lookup (combinational from registered table): hit = valid & tag match. pred_taken = hit & (jal | ctr[1]). pred_target = entry target; 0 when no hit.
- Resolution (ex_valid=1, state IDLE). Actual: taken = ex_taken for 01, 1 for 10/11, 0 for 00. act_pc = ex_target if taken, else {0, ex_pc}+4 (32-bit).
- Mispredict = ex_pred_taken != taken, or (taken & ex_pred_taken & {0, ex_pred_target} != ex_target).
- On mispredict: redirect=1, flush=1, redirect_pc=act_pc. Otherwise redirect=flush=0, redirect_pc=0.
- Table update, at the resolving edge, at index/tag of ex_pc:
  - 01 hit: ctr saturating ±1; target <= ex_target[PC_W-1:0] if taken.
  - 01 miss, taken: allocate, ctr=10, jal=0.
  - 01 miss, not taken: no allocation.
  - 10: allocate/refresh, jal=1, target written.
  - 11: never allocated; a hit is invalidated.
  - 00 with hit: entry invalidated (aliasing).
- mispredict_cnt increments once per mispredicting instruction; holds at 0xFFFF.
- FSM:
  - IDLE: resolution enabled. ex_valid & ex_hold at an edge -> HELD.
  - HELD: same instruction still in EX. No table update, no count. redirect/flush/redirect_pc are still recomputed each cycle. ex_hold=0 at an edge -> IDLE.

## Timing
- Prediction: zero latency, same cycle as if_pc.
- Redirect/flush: combinational, same cycle as EX resolution. The pipeline loads redirect_pc at the next edge.
- Table writes take effect next cycle. A same-cycle lookup at the written index returns old contents (no bypass).
- Reset (any time, including in HELD): all valid=0, ctr=01, jal=0, targets=0, state IDLE, mispredict_cnt=0. Outputs: pred_taken=0, pred_target=0. redirect/flush/redirect_pc are 0 while ex_valid=0.
- ex_valid=0: no update, redirect=flush=0.

## Configuration
- BRANCH_PREDICT_EN defined: table, lookup and updates as above.
- Undefined: no table storage. pred_taken=0, pred_target=0. Every taken control transfer mispredicts (redirect to ex_target, flush). mispredict_cnt and FSM unchanged.

## Test plan
- After reset, if_pc=0x040 -> pred_taken=0, pred_target=0, mispredict_cnt=0.
- Branch ex_pc=0x040, ex_taken=1, ex_target=0x060, ex_pred_taken=0 -> redirect=1, flush=1, redirect_pc=0x060, cnt=1. Next cycle if_pc=0x040 -> pred_taken=1, pred_target=0x060.
- Same branch resolves not-taken twice (pred 1, then 0) -> first: redirect_pc=0x044, ctr 10->01; second: no redirect; then if_pc=0x040 -> pred_taken=0.
- JAL ex_pc=0x010, target 0x100, ex_hold=1 for 3 cycles -> redirect high all 4 cycles, cnt increments by exactly 1, single table write.
- Non-branch at 0x080 with ex_pred_taken=1 (aliasing hit) -> redirect_pc=0x084, entry invalidated. Reset asserted in HELD -> outputs and cnt zero immediately.
- BRANCH_PREDICT_EN undefined: taken branch 0x040->0x060 repeated -> redirect every time; pred_taken stays 0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and EX-resolution redirect controller.
// Define BRANCH_PREDICT_EN to build the direct-mapped history/target table; otherwise no prediction is made.
module branch_predict_ctrl #(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_hold,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [1:0]      ex_ctrl_transfer,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            flush,
  output logic [15:0]     mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_cnt;
  logic        w_taken;
  logic        w_mispredict;
  logic        w_resolve;
  logic [31:0] w_act_pc;

  always_comb begin
    w_taken = 1'b0;
    case (ex_ctrl_transfer)
      2'b01:   w_taken = ex_taken;
      2'b10,
      2'b11:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_act_pc = w_taken ? ex_target : ({{(32-PC_W){1'b0}}, ex_pc} + 32'd4);

`ifdef BRANCH_PREDICT_EN
  assign w_mispredict = (ex_pred_taken != w_taken) |
                        (w_taken & ex_pred_taken & ({{(32-PC_W){1'b0}}, ex_pred_target} != ex_target));
`else
  // Nothing is ever predicted taken, so every taken transfer is a mispredict.
  logic w_unused_pred;
  assign w_unused_pred = ^{if_pc, ex_pred_taken, ex_pred_target};
  assign w_mispredict  = w_taken;
`endif

  assign redirect       = ex_valid & w_mispredict;
  assign flush          = redirect;
  assign redirect_pc    = redirect ? w_act_pc : 32'd0;
  assign mispredict_cnt = r_cnt;
  // A held instruction keeps driving redirect but must not update state twice.
  assign w_resolve      = ex_valid & (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (ex_valid && ex_hold) r_state <= S_HELD;
        S_HELD:  if (!ex_hold) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_resolve && w_mispredict && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_jal;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_if_hit;
  logic             w_ex_hit;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

  assign pred_taken  = w_if_hit & (r_jal[w_if_idx] | r_ctr[w_if_idx][1]);
  assign pred_target = w_if_hit ? r_target[w_if_idx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_jal   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_resolve) begin
      case (ex_ctrl_transfer)
        2'b01: begin
          if (w_ex_hit) begin
            if (ex_taken) begin
              if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
              r_target[w_ex_idx] <= ex_target[PC_W-1:0];
            end else if (r_ctr[w_ex_idx] != 2'b00) begin
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
            end
          end else if (ex_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target[PC_W-1:0];
            r_ctr[w_ex_idx]    <= 2'b10;
            r_jal[w_ex_idx]    <= 1'b0;
          end
        end
        2'b10: begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= ex_target[PC_W-1:0];
          r_jal[w_ex_idx]    <= 1'b1;
        end
        // JALR targets are not stable and non-branch hits are aliases: drop them.
        default: begin
          if (w_ex_hit) r_valid[w_ex_idx] <= 1'b0;
        end
      endcase
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl; expectations follow BRANCH_PREDICT_EN.
module tb_branch_predict_ctrl;

`ifdef BRANCH_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [8:0]  if_pc;
  logic        pred_taken;
  logic [8:0]  pred_target;
  logic        ex_valid;
  logic        ex_hold;
  logic [8:0]  ex_pc;
  logic [1:0]  ex_ctrl_transfer;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [8:0]  ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  branch_predict_ctrl #(.PC_W(9), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_hold(ex_hold), .ex_pc(ex_pc),
    .ex_ctrl_transfer(ex_ctrl_transfer), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge and are sampled 1ns later, far from the rising edge.
  task automatic applyStimulus(input logic v, input logic hold, input logic [8:0] pc,
                               input logic [1:0] ctrl, input logic tk, input logic [31:0] tgt,
                               input logic ptk, input logic [8:0] ptgt, input logic [8:0] ifpc);
    @(negedge clk);
    ex_valid = v; ex_hold = hold; ex_pc = pc; ex_ctrl_transfer = ctrl;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt; if_pc = ifpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic checkRedirect(input string tag, input logic r, input logic [31:0] pc);
    checkOutput({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
    checkOutput({tag, "_flush"}, {31'd0, flush}, {31'd0, r});
    checkOutput({tag, "_rpc"}, redirect_pc, pc);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_hold = 0; ex_pc = '0; ex_ctrl_transfer = 2'b00; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0; if_pc = 9'h040;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rst_pred_target", {23'd0, pred_target}, 32'd0);
    checkOutput("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    checkRedirect("rst", 1'b0, 32'd0);

    // Cold taken branch mispredicts and allocates; no same-cycle bypass.
    applyStimulus(1, 0, 9'h040, 2'b01, 1, 32'h060, 0, 9'h000, 9'h040);
    checkRedirect("br_cold", 1'b1, 32'h060);
    checkOutput("br_cold_nobypass", {31'd0, pred_taken}, 32'd0);
    expCnt++;
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h040);
    checkOutput("br_alloc_pred", {31'd0, pred_taken}, {31'd0, PRED_EN});
    checkOutput("br_alloc_tgt", {23'd0, pred_target}, PRED_EN ? 32'h060 : 32'h0);
    checkOutput("br_alloc_cnt", {16'd0, mispredict_cnt}, expCnt);
    checkRedirect("idle", 1'b0, 32'd0);

    // Predicted-taken branch falls through: redirect to pc+4, counter 10->01.
    applyStimulus(1, 0, 9'h040, 2'b01, 0, 32'h060, PRED_EN, PRED_EN ? 9'h060 : 9'h000, 9'h040);
    checkRedirect("br_nt1", PRED_EN, PRED_EN ? 32'h044 : 32'h0);
    expCnt += PRED_EN ? 1 : 0;
    applyStimulus(1, 0, 9'h040, 2'b01, 0, 32'h060, 0, 9'h000, 9'h040);
    checkOutput("br_nt2_pred", {31'd0, pred_taken}, 32'd0);
    checkRedirect("br_nt2", 1'b0, 32'd0);
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h040);
    checkOutput("br_nt_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("br_nt_cnt", {16'd0, mispredict_cnt}, expCnt);

    // JAL held in EX for three extra cycles: redirect every cycle, one count.
    applyStimulus(1, 1, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
    checkRedirect("jal_c0", 1'b1, 32'h100);
    expCnt++;
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1, 1, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
      checkRedirect("jal_held", 1'b1, 32'h100);
      checkOutput("jal_held_cnt", {16'd0, mispredict_cnt}, expCnt);
      checkOutput("jal_held_pred", {31'd0, pred_taken}, {31'd0, PRED_EN});
      checkOutput("jal_held_tgt", {23'd0, pred_target}, PRED_EN ? 32'h100 : 32'h0);
    end
    applyStimulus(1, 0, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
    checkRedirect("jal_c3", 1'b1, 32'h100);
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h010);
    checkOutput("jal_cnt", {16'd0, mispredict_cnt}, expCnt);

    // Branch at 0x080 (aliases 0x040's slot) then a non-branch hitting that entry.
    applyStimulus(1, 0, 9'h080, 2'b01, 1, 32'h0C0, 0, 9'h000, 9'h080);
    checkRedirect("br80", 1'b1, 32'h0C0);
    expCnt++;
    applyStimulus(1, 0, 9'h080, 2'b00, 0, 32'h0, PRED_EN, PRED_EN ? 9'h0C0 : 9'h000, 9'h080);
    checkOutput("alias_pred", {31'd0, pred_taken}, {31'd0, PRED_EN});
    checkRedirect("alias", PRED_EN, PRED_EN ? 32'h084 : 32'h0);
    expCnt += PRED_EN ? 1 : 0;
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h080);
    checkOutput("alias_inval", {31'd0, pred_taken}, 32'd0);
    checkOutput("alias_cnt", {16'd0, mispredict_cnt}, expCnt);

    // JALR with a stale predicted target: redirect and invalidate.
    applyStimulus(1, 0, 9'h010, 2'b11, 0, 32'h200, PRED_EN, PRED_EN ? 9'h100 : 9'h000, 9'h010);
    checkRedirect("jalr", 1'b1, 32'h200);
    expCnt++;
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h010);
    checkOutput("jalr_inval", {31'd0, pred_taken}, 32'd0);
    checkOutput("jalr_cnt", {16'd0, mispredict_cnt}, expCnt);

    // Reset while HELD clears everything at once and returns to IDLE.
    applyStimulus(1, 1, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
    expCnt++;
    applyStimulus(1, 1, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
    checkOutput("held_pre_rst_pred", {31'd0, pred_taken}, {31'd0, PRED_EN});
    checkOutput("held_pre_rst_cnt", {16'd0, mispredict_cnt}, expCnt);
    reset = 1'b1;
    ex_valid = 1'b0;
    #1;
    checkOutput("held_rst_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("held_rst_tgt", {23'd0, pred_target}, 32'd0);
    checkOutput("held_rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    checkRedirect("held_rst", 1'b0, 32'd0);
    expCnt = 0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 9'h010, 2'b10, 0, 32'h100, 0, 9'h000, 9'h010);
    checkRedirect("post_rst_jal", 1'b1, 32'h100);
    expCnt++;
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h010);
    checkOutput("post_rst_cnt", {16'd0, mispredict_cnt}, expCnt);
    checkOutput("post_rst_pred", {31'd0, pred_taken}, {31'd0, PRED_EN});

`ifndef BRANCH_PREDICT_EN
    // Without a table the same taken branch redirects every time.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 0, 9'h040, 2'b01, 1, 32'h060, 0, 9'h000, 9'h040);
      checkRedirect("nopred_br", 1'b1, 32'h060);
      checkOutput("nopred_pred", {31'd0, pred_taken}, 32'd0);
      expCnt++;
    end
    applyStimulus(0, 0, 9'h000, 2'b00, 0, 32'h0, 0, 9'h000, 9'h040);
    checkOutput("nopred_cnt", {16'd0, mispredict_cnt}, expCnt);
    checkOutput("nopred_tgt", {23'd0, pred_target}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
